// File: rtl/gpu_pkg.sv
// Shared GPU definitions: coordinate/address widths, point-buffer depth and
// the point-reader state encoding used by the rasterizer and memory blocks.
package gpu_pkg;

  localparam int unsigned CW    = 4;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 201;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

endpackage

// File: rtl/point_skid_fifo.sv
// Two-entry FIFO holding x/y coordinate pairs between the point buffer read
// port and the streaming output.
module point_skid_fifo #(
  parameter int unsigned CW = gpu_pkg::CW
) (
  input  logic          c,
  input  logic          rst,
  input  logic          push,
  input  logic [CW-1:0] push_x,
  input  logic [CW-1:0] push_y,
  input  logic          pop,
  output logic [CW-1:0] head_x,
  output logic [CW-1:0] head_y,
  output logic          full,
  output logic          empty,
  output logic [1:0]    level
);

  logic [CW-1:0] x_q [2];
  logic [CW-1:0] y_q [2];
  logic          wr_q;
  logic          rd_q;
  logic [1:0]    level_q;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level_q == 2'd2);
  assign empty   = (level_q == 2'd0);
  assign level   = level_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head_x  = x_q[rd_q];
  assign head_y  = y_q[rd_q];

  // Storage needs no reset; it is only observed while non-empty.
  always_ff @(posedge c) begin
    if (push_ok) begin
      x_q[wr_q] <= push_x;
      y_q[wr_q] <= push_y;
    end
  end

  always_ff @(posedge c) begin
    if (rst) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      level_q <= 2'd0;
    end else begin
      if (push_ok) wr_q <= ~wr_q;
      if (pop_ok)  rd_q <= ~rd_q;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 2'd1;
        2'b01:   level_q <= level_q - 2'd1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/point_reader.sv
// Streams a burst of points from the point buffer's synchronous read port to a
// valid/ready output, keeping at most two points buffered or in flight.
module point_reader #(
  parameter int unsigned CW    = gpu_pkg::CW,
  parameter int unsigned AW    = gpu_pkg::AW,
  parameter int unsigned DEPTH = gpu_pkg::DEPTH
) (
  input  logic          c,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] count,
  output logic          busy,
  output logic          done,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [CW-1:0] mem_x,
  input  logic [CW-1:0] mem_y,
  output logic [CW-1:0] px,
  output logic [CW-1:0] py,
  output logic          pvalid,
  input  logic          pready
);

  import gpu_pkg::*;

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] rd_left_q, rd_left_d;
  logic [AW-1:0] xfer_left_q, xfer_left_d;
  logic          rd_valid_q;
  logic [AW-1:0] base_wrapped;
  logic [2:0]    in_use;
  logic          xfer;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [1:0]    fifo_level;
  logic [CW-1:0] head_x;
  logic [CW-1:0] head_y;

  assign base_wrapped = AW'(32'(base) % DEPTH);

  // Credit: points sitting in the FIFO plus the read whose data lands this cycle.
  assign in_use    = {1'b0, fifo_level} + {2'b00, rd_valid_q};
  assign mem_rd_en = (state_q == StRead) && !fifo_full && (in_use < 3'd2);
  assign mem_addr  = addr_q;

  // Returning data is presented directly when the FIFO is empty, so a point
  // can leave in the same cycle it arrives.
  assign pvalid = !fifo_empty || rd_valid_q;
  assign px     = !fifo_empty ? head_x : (rd_valid_q ? mem_x : '0);
  assign py     = !fifo_empty ? head_y : (rd_valid_q ? mem_y : '0);
  assign xfer   = pvalid && pready;

  assign fifo_push = rd_valid_q && !(fifo_empty && pready);
  assign fifo_pop  = xfer && !fifo_empty;

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_left_d   = rd_left_q;
    xfer_left_d = xfer_left_q;
    if (xfer) xfer_left_d = xfer_left_q - AW'(1);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d      = base_wrapped;
          rd_left_d   = count;
          xfer_left_d = count;
          state_d     = (count == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        if (mem_rd_en) begin
          rd_left_d = rd_left_q - AW'(1);
          // Keep the final address on the bus once the last read is issued.
          if (rd_left_q == AW'(1)) begin
            state_d = StDrain;
          end else begin
            addr_d = (addr_q == LastAddr) ? '0 : addr_q + AW'(1);
          end
        end
      end
      StDrain: begin
        if (xfer && (xfer_left_q == AW'(1))) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge c) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      rd_left_q   <= '0;
      xfer_left_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_left_q   <= rd_left_d;
      xfer_left_q <= xfer_left_d;
      rd_valid_q  <= mem_rd_en;
    end
  end

  point_skid_fifo #(
    .CW (CW)
  ) u_fifo (
    .c      (c),
    .rst    (rst),
    .push   (fifo_push),
    .push_x (mem_x),
    .push_y (mem_y),
    .pop    (fifo_pop),
    .head_x (head_x),
    .head_y (head_y),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

endmodule

// File: tb/tb_point_reader.sv
// Scoreboard bench for point_reader: stimulus queues expected points and read
// addresses, a negedge monitor compares whatever the DUT presents.
module tb_point_reader;

  localparam int unsigned CW    = 4;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 201;

  logic          c = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base;
  logic [AW-1:0] count;
  logic          busy;
  logic          done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] mem_x = '0;
  logic [CW-1:0] mem_y = '0;
  logic [CW-1:0] px;
  logic [CW-1:0] py;
  logic          pvalid;
  logic          pready;

  point_reader #(
    .CW    (CW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) dut (
    .c         (c),
    .rst       (rst),
    .start     (start),
    .base      (base),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_x     (mem_x),
    .mem_y     (mem_y),
    .px        (px),
    .py        (py),
    .pvalid    (pvalid),
    .pready    (pready)
  );

  always #5 c = ~c;

  int cyc = 0;
  always @(posedge c) cyc <= cyc + 1;

  // Point buffer model: x = addr mod 16, y = addr / 16, except addresses 0..4.
  logic [CW-1:0] mx [DEPTH];
  logic [CW-1:0] my [DEPTH];
  always @(posedge c) begin
    if (mem_rd_en) begin
      mem_x <= mx[mem_addr];
      mem_y <= my[mem_addr];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int exp_pt[$];
  int exp_addr[$];

  int acc;
  int n_rd, n_xfer, n_done;
  int first_rd, first_pv, done_cyc, last_xfer;
  logic          stall_prev = 1'b0;
  logic [CW-1:0] hold_x, hold_y;

  always @(negedge c) begin
    if (mem_rd_en) begin
      if (first_rd < 0) first_rd = cyc;
      check("outstanding_le_2", int'((n_rd + 1 - n_xfer) <= 2), 1);
      n_rd++;
      if (exp_addr.size() == 0) check("unexpected_read_addr", int'(mem_addr), -1);
      else check("read_addr", int'(mem_addr), exp_addr.pop_front());
    end
    if (pvalid && first_pv < 0) first_pv = cyc;
    if (stall_prev) begin
      check("stall_pvalid", int'(pvalid), 1);
      check("stall_px", int'(px), int'(hold_x));
      check("stall_py", int'(py), int'(hold_y));
    end
    stall_prev = pvalid && !pready && !rst;
    hold_x = px;
    hold_y = py;
    if (pvalid && pready && !rst) begin
      n_xfer++;
      last_xfer = cyc;
      if (exp_pt.size() == 0) check("unexpected_point", int'({px, py}), -1);
      else check("point", int'({px, py}), exp_pt.pop_front());
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic push_pt(input int x, input int y, input int a);
    exp_pt.push_back((x << CW) | y);
    exp_addr.push_back(a);
  endtask

  // Returns at #1 inside the first cycle after the accepting edge.
  task automatic start_burst(input int b, input int n);
    start = 1'b1;
    base  = AW'(b);
    count = AW'(n);
    tick();
    start    = 1'b0;
    acc      = cyc;
    n_rd     = 0;
    n_xfer   = 0;
    n_done   = 0;
    first_rd = -1;
    first_pv = -1;
    done_cyc = -1;
    last_xfer = -1;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      tick();
      k++;
    end
    if (n_done == 0) check("done_timeout", 0, 1);
    repeat (3) tick();
  endtask

  task automatic end_of_burst(input string tag, input int n);
    check({tag, "_done_pulses"}, n_done, 1);
    check({tag, "_rd_count"}, n_rd, n);
    check({tag, "_xfer_count"}, n_xfer, n);
    check({tag, "_pts_left"}, exp_pt.size(), 0);
    check({tag, "_addrs_left"}, exp_addr.size(), 0);
    check({tag, "_busy_after"}, int'(busy), 0);
  endtask

  task automatic basic_burst(input string tag);
    for (int i = 0; i < 5; i++) push_pt(i + 1, 2 * (i + 1), i);
    start_burst(0, 5);
    wait_done(40);
    check({tag, "_first_rd_cyc"}, first_rd, acc);
    check({tag, "_first_pv_cyc"}, first_pv, acc + 1);
    check({tag, "_done_cyc"}, done_cyc, acc + 6);
    end_of_burst(tag, 5);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mx[i] = CW'(i % 16);
      my[i] = CW'(i / 16);
    end
    for (int i = 0; i < 5; i++) begin
      mx[i] = CW'(i + 1);
      my[i] = CW'(2 * (i + 1));
    end
    rst = 1'b1; start = 1'b0; base = '0; count = '0; pready = 1'b1;
    tick();
    // Reset state, with start asserted to show reset wins.
    start = 1'b1; count = AW'(3);
    tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rd_en", int'(mem_rd_en), 0);
    check("rst_pvalid", int'(pvalid), 0);
    check("rst_px_py", int'({px, py}), 0);
    check("rst_addr", int'(mem_addr), 0);
    start = 1'b0; rst = 1'b0;
    tick();
    check("idle_busy", int'(busy), 0);

    basic_burst("basic");

    // Address wrap at DEPTH-1.
    push_pt(7, 12, 199); push_pt(8, 12, 200); push_pt(1, 2, 0); push_pt(2, 4, 1);
    start_burst(199, 4);
    check("wrap_busy", int'(busy), 1);
    wait_done(40);
    end_of_burst("wrap", 4);

    // base >= DEPTH: 250 reduces to 49.
    push_pt(1, 3, 49); push_pt(2, 3, 50);
    start_burst(250, 2);
    wait_done(40);
    end_of_burst("modbase", 2);

    // Backpressure pattern 1,0,0,1,0,1 then held high.
    push_pt(4, 1, 20); push_pt(5, 1, 21); push_pt(6, 1, 22);
    start_burst(20, 3);
    begin
      logic [5:0] pat;
      pat = 6'b101001;
      for (int i = 0; i < 6; i++) begin
        pready = pat[i];
        tick();
      end
    end
    pready = 1'b1;
    wait_done(40);
    check("stall_done_cyc", done_cyc, last_xfer + 1);
    end_of_burst("stall", 3);

    // Zero-length burst.
    start_burst(10, 0);
    check("zero_done_now", int'(done), 1);
    wait_done(10);
    check("zero_done_cyc", done_cyc, acc);
    check("zero_pv", first_pv, -1);
    end_of_burst("zero", 0);

    // Second start mid-burst is ignored.
    push_pt(4, 6, 100); push_pt(5, 6, 101); push_pt(6, 6, 102); push_pt(7, 6, 103);
    start_burst(100, 4);
    start = 1'b1; base = AW'(50); count = AW'(2);
    tick();
    start = 1'b0;
    wait_done(40);
    check("restart_done_cyc", done_cyc, last_xfer + 1);
    end_of_burst("restart", 4);

    // Reset mid-burst after the second read, with pready low.
    pready = 1'b0;
    for (int i = 0; i < 5; i++) push_pt(i + 1, 2 * (i + 1), i);
    start_burst(0, 5);
    tick();
    tick();
    check("midrst_reads", n_rd, 2);
    rst = 1'b1;
    exp_pt.delete();
    exp_addr.delete();
    tick();
    rst = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_rd_en", int'(mem_rd_en), 0);
    check("midrst_pvalid", int'(pvalid), 0);
    check("midrst_px_py", int'({px, py}), 0);
    check("midrst_addr", int'(mem_addr), 0);
    tick();
    check("midrst_pvalid_late", int'(pvalid), 0);
    pready = 1'b1;
    basic_burst("afterrst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
